// File: rtl/sspi_regbank.sv
// sspi_regbank: control/status registers plus a sample FIFO read port,
// sitting behind the SPI slave's addr/dout/rd/we strobes.
module sspi_regbank #(
   parameter int unsigned DEPTH = 16,
   parameter logic [7:0]  ID    = 8'hD5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   input  logic       rd,
   input  logic       we,
   output logic [7:0] rdata,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic       trig_in,
   output logic [7:0] ctrl,
   output logic [7:0] trig_level,
   output logic [7:0] div,
   output logic       start
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   localparam logic [6:0] A_ID     = 7'h00;
   localparam logic [6:0] A_CTRL   = 7'h01;
   localparam logic [6:0] A_TRIG   = 7'h02;
   localparam logic [6:0] A_DIV    = 7'h03;
   localparam logic [6:0] A_STATUS = 7'h04;
   localparam logic [6:0] A_CMD    = 7'h05;
   localparam logic [6:0] A_CNT    = 7'h06;
   localparam logic [6:0] A_DATA   = 7'h07;

   logic [7:0]    ctrl_q, trig_level_q, div_q;
   logic          start_q;
   logic          trig_q, ovf_q, udf_q;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;

   logic full, empty;
   logic wr_cmd, wr_status;
   logic flush, pop_req, pop_ok, push_ok;
   logic ovf_set, udf_set;

   // Strobe decode and FIFO push/pop qualification
   always_comb begin
      full      = (count == FULL_CNT);
      empty     = (count == '0);
      wr_cmd    = we && (addr == A_CMD);
      wr_status = we && (addr == A_STATUS);
      flush     = wr_cmd && wdata[1];
      pop_req   = rd && (addr == A_DATA);
      pop_ok    = pop_req && !empty;
      udf_set   = pop_req && empty;
      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      push_ok   = s_valid && !flush && (!full || pop_req);
      ovf_set   = s_valid && full && !pop_req && !flush;
   end

   // Control registers, start pulse and sticky flags (set beats W1C)
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q       <= '0;
         trig_level_q <= 8'h80;
         div_q        <= '0;
         start_q      <= 1'b0;
         trig_q       <= 1'b0;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
      end else begin
         if (we && addr == A_CTRL) ctrl_q       <= wdata;
         if (we && addr == A_TRIG) trig_level_q <= wdata;
         if (we && addr == A_DIV)  div_q        <= wdata;
         start_q <= wr_cmd && wdata[0];
         trig_q  <= (trig_q & ~(wr_status & wdata[0])) | trig_in;
         ovf_q   <= (ovf_q  & ~(wr_status & wdata[1])) | ovf_set;
         udf_q   <= (udf_q  & ~(wr_status & wdata[2])) | udf_set;
      end
   end

   // FIFO pointers and level
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem[wptr] <= s_data;
   end

   // Combinational read mux, valid in the same cycle as rd
   always_comb begin
      rdata = '0;
      case (addr)
         A_ID:     rdata = ID;
         A_CTRL:   rdata = ctrl_q;
         A_TRIG:   rdata = trig_level_q;
         A_DIV:    rdata = div_q;
         A_STATUS: rdata = {3'b000, full, empty, udf_q, ovf_q, trig_q};
         A_CNT:    rdata = 8'(count);
         A_DATA:   rdata = empty ? 8'h00 : mem[rptr];
         default:  rdata = '0;
      endcase
   end

   assign s_ready    = ~full;
   assign ctrl       = ctrl_q;
   assign trig_level = trig_level_q;
   assign div        = div_q;
   assign start      = start_q;

endmodule

// File: tb/tb_sspi_regbank.sv
// Directed testbench for sspi_regbank (DEPTH=16).
module tb_sspi_regbank;

   logic       clk = 1'b0;
   logic       rst, rd, we, s_valid, trig_in;
   logic [6:0] addr;
   logic [7:0] wdata, s_data;
   logic [7:0] rdata, ctrl, trig_level, div;
   logic       s_ready, start;

   int errors = 0;
   int checks = 0;

   sspi_regbank #(.DEPTH(16), .ID(8'hD5)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rd(rd), .we(we),
      .rdata(rdata), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .trig_in(trig_in), .ctrl(ctrl), .trig_level(trig_level), .div(div),
      .start(start)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a read strobe, check rdata in that same cycle, then clock it
   task automatic rd_reg(input logic [6:0] a, input logic [7:0] exp, input string tag);
      addr = a;
      rd   = 1'b1;
      #1;
      chk(tag, rdata, exp);
      tick();
      rd = 1'b0;
   endtask

   task automatic wr(input logic [6:0] a, input logic [7:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      s_data  = d;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rd = 1'b0; we = 1'b0; s_valid = 1'b0; trig_in = 1'b0;
      addr = '0; wdata = '0; s_data = '0;
      tick(); tick();
      rst = 1'b0;

      // reset state
      chk("rst_ctrl", ctrl, 8'h00);
      chk("rst_trig_level", trig_level, 8'h80);
      chk("rst_div", div, 8'h00);
      chk("rst_start", {7'b0, start}, 8'h00);
      chk("rst_s_ready", {7'b0, s_ready}, 8'h01);

      rd_reg(7'h00, 8'hD5, "rd_id");
      rd_reg(7'h01, 8'h00, "rd_ctrl0");
      rd_reg(7'h02, 8'h80, "rd_trig0");
      rd_reg(7'h03, 8'h00, "rd_div0");
      rd_reg(7'h04, 8'h08, "rd_status0");
      rd_reg(7'h05, 8'h00, "rd_cmd0");
      rd_reg(7'h06, 8'h00, "rd_cnt0");
      rd_reg(7'h07, 8'h00, "rd_data_empty");
      rd_reg(7'h04, 8'h0C, "status_udf");
      wr(7'h04, 8'h04);
      rd_reg(7'h04, 8'h08, "status_udf_clr");
      rd_reg(7'h40, 8'h00, "rd_unmapped");

      // register writes
      wr(7'h01, 8'h5A);
      chk("ctrl_out", ctrl, 8'h5A);
      wr(7'h03, 8'h13);
      chk("div_out", div, 8'h13);
      wr(7'h02, 8'h33);
      chk("trig_level_out", trig_level, 8'h33);
      rd_reg(7'h01, 8'h5A, "rd_ctrl");
      rd_reg(7'h03, 8'h13, "rd_div");
      rd_reg(7'h02, 8'h33, "rd_trig");
      wr(7'h00, 8'hFF);
      rd_reg(7'h00, 8'hD5, "id_ro");

      // start pulse
      addr = 7'h05; wdata = 8'h01; we = 1'b1;
      #1;
      chk("start_during_we", {7'b0, start}, 8'h00);
      tick();
      we = 1'b0;
      chk("start_pulse", {7'b0, start}, 8'h01);
      tick();
      chk("start_end", {7'b0, start}, 8'h00);
      rd_reg(7'h05, 8'h00, "rd_cmd");

      // fill, overflow, drain, underflow
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      rd_reg(7'h06, 8'h10, "cnt_full");
      chk("s_ready_full", {7'b0, s_ready}, 8'h00);
      rd_reg(7'h04, 8'h10, "status_full");
      push(8'hAA);
      rd_reg(7'h04, 8'h12, "status_ovf");
      rd_reg(7'h06, 8'h10, "cnt_after_drop");
      wr(7'h07, 8'h77);
      rd_reg(7'h06, 8'h10, "we_fifo_ignored");
      wr(7'h04, 8'h02);
      for (int i = 0; i < 16; i++) rd_reg(7'h07, 8'(8'h10 + i), "pop_order");
      rd_reg(7'h06, 8'h00, "cnt_drained");
      rd_reg(7'h07, 8'h00, "pop_17th");
      rd_reg(7'h04, 8'h0C, "status_udf2");
      wr(7'h04, 8'h04);

      // push and pop together while full
      for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
      addr = 7'h07; rd = 1'b1; s_data = 8'h99; s_valid = 1'b1;
      #1;
      chk("pp_full_head", rdata, 8'h20);
      tick();
      rd = 1'b0; s_valid = 1'b0;
      rd_reg(7'h06, 8'h10, "pp_full_cnt");
      rd_reg(7'h04, 8'h10, "pp_full_no_ovf");
      for (int i = 1; i < 16; i++) rd_reg(7'h07, 8'(8'h20 + i), "pp_drain");
      rd_reg(7'h07, 8'h99, "pp_last");

      // push and pop together while empty
      addr = 7'h07; rd = 1'b1; s_data = 8'h55; s_valid = 1'b1;
      #1;
      chk("pp_empty_data", rdata, 8'h00);
      tick();
      rd = 1'b0; s_valid = 1'b0;
      rd_reg(7'h06, 8'h01, "pp_empty_cnt");
      rd_reg(7'h04, 8'h04, "pp_empty_udf");
      rd_reg(7'h07, 8'h55, "pp_empty_pushed");
      wr(7'h04, 8'h04);

      // flush together with a push into a full FIFO
      for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
      addr = 7'h05; wdata = 8'h02; we = 1'b1; s_data = 8'hEE; s_valid = 1'b1;
      tick();
      we = 1'b0; s_valid = 1'b0;
      rd_reg(7'h06, 8'h00, "flush_cnt");
      rd_reg(7'h04, 8'h08, "flush_no_ovf");
      chk("flush_s_ready", {7'b0, s_ready}, 8'h01);

      // flush and start in one write, sticky flag survives flush
      push(8'h01);
      rd_reg(7'h07, 8'h01, "pre_udf_pop");
      rd_reg(7'h07, 8'h00, "pre_udf_empty");
      push(8'h02);
      wr(7'h05, 8'h03);
      chk("flush_start_pulse", {7'b0, start}, 8'h01);
      rd_reg(7'h04, 8'h0C, "flush_keeps_udf");
      wr(7'h04, 8'h04);

      // trigger set beats simultaneous W1C
      addr = 7'h04; wdata = 8'h01; we = 1'b1; trig_in = 1'b1;
      tick();
      we = 1'b0; trig_in = 1'b0;
      rd_reg(7'h04, 8'h09, "trig_set_wins");
      wr(7'h04, 8'h01);
      rd_reg(7'h04, 8'h08, "trig_cleared");

      // reset mid-stream discards FIFO and strobes
      push(8'hC1);
      push(8'hC2);
      rst = 1'b1; s_valid = 1'b1; s_data = 8'hC3; addr = 7'h01; wdata = 8'hFF; we = 1'b1;
      tick();
      rst = 1'b0; s_valid = 1'b0; we = 1'b0;
      chk("rst_mid_ctrl", ctrl, 8'h00);
      rd_reg(7'h06, 8'h00, "rst_mid_cnt");
      rd_reg(7'h04, 8'h08, "rst_mid_status");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
